pulse_bcd_counter: RTL and testbench
====================================

Name: pulse_bcd_counter

Overview:
- Downstream stage of the hold-then-release pulse detector.
- Consumes its single-cycle event pulse and counts events as two BCD digits (00-99, wrapping), with a sticky overflow flag.
- Drives a time-multiplexed two-digit seven-segment display.
- Sits between the detector output and the board display pins.

Parameters:
- SCAN_DIV, 16'd50000: clk cycles per display digit slot. Legal range 2..65535.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- pulse_in  input  1  event pulse from the upstream detector; nominally one cycle wide.
- clr  input  1  synchronous count clear, active-high.
- bcd_ones  output  4  ones digit, 0-9.
- bcd_tens  output  4  tens digit, 0-9.
- ovf  output  1  sticky; set on a 99->00 wrap.
- dig_en  output  2  one-hot digit enable: bit0 = ones, bit1 = tens; active-high.
- seg  output  7  segments {g,f,e,d,c,b,a}; active-high; registered.

Behaviour:
- Reset (rst=1 at posedge) sets:
  - bcd_ones=0, bcd_tens=0, ovf=0.
  - scan counter=0.
  - dig_en=2'b01, seg=7'h3F (shows "0").
  - Edge register pulse_d=1, so an input held high through reset is not counted.
  - rst overrides every other input.
- Edge detect:
  - pulse_d <= pulse_in every cycle.
  - Event = pulse_in & ~pulse_d.
  - An input held high for N cycles counts once.
  - Back-to-back pulses need at least one low cycle between them to count twice.
- Count update, on the posedge where event=1 (new value visible the following cycle; latency 1):
  - ones<9: ones+1.
  - ones==9, tens<9: ones=0, tens+1.
  - ones==9, tens==9: ones=0, tens=0, ovf=1.
- Digits never hold values 10-15.
- clr=1: ones=0, tens=0, ovf=0. clr has priority over a same-cycle event; that event is discarded.
- pulse_d still updates during clr, so a pulse spanning the clr cycle is not counted afterwards.
- Display scan:
  - 16-bit scan counter counts 0..SCAN_DIV-1, then returns to 0.
  - On the cycle it equals SCAN_DIV-1, dig_en toggles between 01 and 10.
  - dig_en is never 00 or 11 outside reset.
- seg is a registered decode of the currently selected digit:
  - Decode uses the current count register and the next-state dig_en, so seg and dig_en change on the same edge.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any other value decodes to 00 (blank; unreachable).
- Count changes mid-slot appear on seg one cycle after the count register changes.
- Scan runs independently of clr and events; only rst resets it.

Test Plan:
- Reset: hold pulse_in=1 during rst, release rst, keep pulse_in=1 for 5 cycles -> count stays 00; dig_en=01, seg=3F.
- Counting: 13 single-cycle pulses separated by 2 low cycles -> after each pulse the count updates next cycle; final tens=1, ones=3, ovf=0.
- Held input: pulse_in high for 20 cycles, then low -> count increases by exactly 1.
- Wrap: 100 pulses from 00 -> tens=0, ones=0, ovf=1. One more pulse -> 01 with ovf still 1.
- Clear priority: clr=1 on the same cycle as an event edge at count 42 -> next cycle count=00, ovf=0. Pulse still high on the next cycle -> no count.
- Scan (SCAN_DIV=4, count 37): dig_en pattern is 01 for 4 cycles, 10 for 4 cycles, repeating. seg is 07 while dig_en=01 and 4F while dig_en=10, changing on the same edge as dig_en.

Source files
------------

// File: rtl/pulse_bcd_counter.sv
// Two-digit BCD event counter fed by a single-cycle pulse detector, with a
// sticky wrap flag and a time-multiplexed seven-segment display driver.
module pulse_bcd_counter #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  input  logic       clr,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic       ovf,
  output logic [1:0] dig_en,
  output logic [6:0] seg
);

  localparam logic [15:0] SCAN_LAST = SCAN_DIV - 16'd1;

  logic        pulse_d;
  logic        event_w;
  logic [3:0]  ones_nxt;
  logic [3:0]  tens_nxt;
  logic        ovf_nxt;
  logic [15:0] scan_cnt;
  logic [15:0] scan_nxt;
  logic [1:0]  dig_en_nxt;
  logic [3:0]  sel_digit;
  logic [6:0]  seg_nxt;

  // Segment pattern {g,f,e,d,c,b,a}; values above 9 cannot occur and blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Rising-edge event and next count value; clear wins over a same-cycle event.
  always_comb begin
    event_w  = pulse_in & ~pulse_d;
    ones_nxt = bcd_ones;
    tens_nxt = bcd_tens;
    ovf_nxt  = ovf;
    if (clr) begin
      ones_nxt = 4'd0;
      tens_nxt = 4'd0;
      ovf_nxt  = 1'b0;
    end else if (event_w) begin
      if (bcd_ones != 4'd9) begin
        ones_nxt = bcd_ones + 4'd1;
      end else if (bcd_tens != 4'd9) begin
        ones_nxt = 4'd0;
        tens_nxt = bcd_tens + 4'd1;
      end else begin
        ones_nxt = 4'd0;
        tens_nxt = 4'd0;
        ovf_nxt  = 1'b1;
      end
    end
  end

  // Scan slot timing; seg decodes from next dig_en so both move on one edge.
  always_comb begin
    if (scan_cnt == SCAN_LAST) begin
      scan_nxt   = 16'd0;
      dig_en_nxt = {dig_en[0], dig_en[1]};
    end else begin
      scan_nxt   = scan_cnt + 16'd1;
      dig_en_nxt = dig_en;
    end
    sel_digit = dig_en_nxt[0] ? bcd_ones : bcd_tens;
    seg_nxt   = seg_decode(sel_digit);
  end

  // State registers; pulse_d resets high so a level held through reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_d  <= 1'b1;
      bcd_ones <= 4'd0;
      bcd_tens <= 4'd0;
      ovf      <= 1'b0;
      scan_cnt <= 16'd0;
      dig_en   <= 2'b01;
      seg      <= 7'h3F;
    end else begin
      pulse_d  <= pulse_in;
      bcd_ones <= ones_nxt;
      bcd_tens <= tens_nxt;
      ovf      <= ovf_nxt;
      scan_cnt <= scan_nxt;
      dig_en   <= dig_en_nxt;
      seg      <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_bcd_counter.sv
// Bench for pulse_bcd_counter: directed scenarios plus random traffic, all
// checked each cycle against an arithmetic model of count and display scan.
module tb_pulse_bcd_counter;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pulse_in;
  logic       clr;
  logic [3:0] bcd_ones;
  logic [3:0] bcd_tens;
  logic       ovf;
  logic [1:0] dig_en;
  logic [6:0] seg;

  int n_tests = 0;
  int n_fail  = 0;

  pulse_bcd_counter #(.SCAN_DIV(16'(SD))) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .clr(clr),
    .bcd_ones(bcd_ones), .bcd_tens(bcd_tens), .ovf(ovf),
    .dig_en(dig_en), .seg(seg)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model: count as an integer 0..99, scan slot from edges since reset.
  int   m_cnt   = 0;
  bit   m_ovf   = 0;
  bit   m_pd    = 1;
  int   m_k     = 0;
  int   m_dig   = 1;
  int   m_seg   = 'h3F;
  bit   m_valid = 0;

  always @(posedge clk) begin
    bit ev;
    int old_cnt;
    if (rst) begin
      m_cnt = 0; m_ovf = 0; m_pd = 1; m_k = 0;
      m_dig = 1; m_seg = 'h3F; m_valid = 1;
    end else begin
      ev      = pulse_in && !m_pd;
      m_pd    = pulse_in;
      old_cnt = m_cnt;
      m_k++;
      m_dig = (((m_k / SD) % 2) == 1) ? 2 : 1;
      m_seg = seg_tab[(m_dig == 1) ? (old_cnt % 10) : (old_cnt / 10)];
      if (clr) begin
        m_cnt = 0; m_ovf = 0;
      end else if (ev) begin
        if (m_cnt == 99) begin m_cnt = 0; m_ovf = 1; end
        else m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_ones", int'(bcd_ones), m_cnt % 10);
      chk("model_tens", int'(bcd_tens), m_cnt / 10);
      chk("model_ovf",  int'(ovf),      int'(m_ovf));
      chk("model_dig",  int'(dig_en),   m_dig);
      chk("model_seg",  int'(seg),      m_seg);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_n(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1; tick(1);
      pulse_in = 1'b0; tick(2);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(1); clr = 1'b0; tick(1);
  endtask

  initial begin
    int run_len;
    logic [1:0] prev_dig;
    rst = 1'b1; pulse_in = 1'b1; clr = 1'b0;
    tick(2);
    chk("rst_count", {bcd_tens, bcd_ones}, 'h00);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_dig", int'(dig_en), 'b01);
    chk("rst_seg", int'(seg), 'h3F);
    rst = 1'b0;
    tick(5);
    chk("held_thru_rst", {bcd_tens, bcd_ones}, 'h00);
    pulse_in = 1'b0; tick(2);

    pulse_n(13);
    chk("count13", {3'b0, ovf, bcd_tens, bcd_ones}, 'h013);

    pulse_in = 1'b1; tick(20); pulse_in = 1'b0; tick(2);
    chk("held20", {bcd_tens, bcd_ones}, 'h14);

    do_clr();
    pulse_n(100);
    chk("wrap100", {3'b0, ovf, bcd_tens, bcd_ones}, 'h100);
    pulse_n(1);
    chk("wrap101", {3'b0, ovf, bcd_tens, bcd_ones}, 'h101);

    do_clr();
    pulse_n(42);
    chk("pre_clr42", {bcd_tens, bcd_ones}, 'h42);
    pulse_in = 1'b1; clr = 1'b1; tick(1);
    clr = 1'b0;
    chk("clr_prio", {3'b0, ovf, bcd_tens, bcd_ones}, 'h000);
    tick(2);
    chk("clr_span", {bcd_tens, bcd_ones}, 'h00);
    pulse_in = 1'b0; tick(2);

    do_clr();
    pulse_n(37);
    tick(1);
    prev_dig = dig_en;
    run_len  = 0;
    for (int i = 0; i < 20; i++) begin
      chk("scan_seg", int'(seg), (dig_en == 2'b01) ? 'h07 : 'h4F);
      if (dig_en != prev_dig) begin
        if (i > run_len) chk("scan_run", run_len, SD);
        run_len  = 0;
        prev_dig = dig_en;
      end
      run_len++;
      tick(1);
    end
    chk("scan_run_last", int'(run_len >= 1 && run_len <= SD), 1);

    for (int i = 0; i < 600; i++) begin
      pulse_in = ($urandom_range(0, 2) == 0);
      clr      = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    rst = 1'b0; clr = 1'b0; pulse_in = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
